rv32i_sc_core: RTL and testbench
================================

Name: rv32i_sc_core

Overview:
- Single-cycle RV32I integer core: fetch, decode, execute, memory access and writeback complete in one clock per instruction.
- Top-level processor block; the only ports are clock and reset.
- Instruction memory, register file and data memory are internal and preloaded hierarchically by benches.
- Required hierarchy paths:
  - u_regfile.regs[0:31]
  - u_imem.imem[]
  - u_mem.mem[]
- Required internal signal names: pc, instr, opcode, alu_result.

Parameters:
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words.
- DMEM_DEPTH, 256, data memory depth in 32-bit words.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.

Behaviour:
- Reset:
  - rst high at a rising edge sets pc = 0.
  - Register file and memories are not cleared by reset; all three are zero-initialised at time 0.
  - No writeback or store occurs while rst is high.
  - Reset asserted mid-program discards the current instruction.
- Fetch: instr = imem[pc[log2(IMEM_DEPTH)+1:2]], combinational. Upper pc bits ignored, so fetch wraps.
- PC update each non-reset edge:
  - pc + 4 by default.
  - Taken branch: pc + B-immediate.
- Register file:
  - 32 x 32; two combinational read ports, one write port written on the rising edge.
  - x0 reads 0; writes to x0 are discarded.
- Supported opcodes:
  - R-type 0110011: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, selected by funct3/funct7[5].
  - I-type ALU 0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI. Immediate is sign-extended imm[11:0].
  - Load 0000011: rd = mem[(rs1+imm)[log2(DMEM_DEPTH)+1:2]], full word. funct3 ignored; low two address bits ignored.
  - Store 0100011: mem[(rs1+imm) word index] = rs2, full word, written on the rising edge. Immediate = sign-extended {instr[31:25], instr[11:7]}. funct3 ignored, so every store is a word store; low address bits ignored.
  - Branch 1100011: BEQ (funct3 000), BNE (funct3 001). Offset = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}. Other funct3 values are not taken.
- Any other opcode, including the all-zero word: no register or memory write; pc + 4.
- Arithmetic:
  - 32-bit, overflow wraps silently.
  - Shift amount = low 5 bits.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
- Data memory reads are combinational. A load and a later store to the same word in the same cycle cannot occur, since there is one instruction per cycle.

Optional Feature:
- Macro CPU_HALT_EN.
- Defined:
  - Instruction 32'hFFFFFFFF sets an internal sticky flag halted.
  - While halted, pc holds and all register and memory writes are suppressed.
  - Only rst clears halted.
- Undefined: 32'hFFFFFFFF is an unrecognised opcode and behaves as a no-op (pc + 4); no halted flag exists.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH);
  - funct3 constants;
  - alu_op_e enum;
  - XLEN = 32.
- Sub-modules: regfile (instance u_regfile), imem (u_imem), dmem (u_mem).
- ALU and immediate generator are kept inline in the top module.

Test Plan:
- R-type chain: preload x1=10, x2=20, x3=7; imem[0]=add x5,x1,x2; imem[1]=add x6,x5,x3; release reset.
  - After 2 edges: x5=30, x6=37.
  - imem[2]=0 is a no-op.
- I-type: set x1=42; imem[3]=addi x2,x1,5 -> x2=47, x1 unchanged at 42.
- Store: imem[6]=sw x3,8(x1) with x1=42, x3=7 -> mem[12]=7 (address 50, word index 12).
- Load/negative immediate: mem[4]=0xDEADBEEF, x1=20; lw x7,-4(x1) -> x7=0xDEADBEEF. addi x8,x0,-1 -> x8=0xFFFFFFFF.
- Branch and x0:
  - beq x1,x1,+8 skips the next word.
  - bne x1,x1,+8 falls through.
  - add x0,x1,x2 leaves x0=0.
- Reset mid-run: assert rst for one edge after pc=0x10 -> pc=0 next cycle, no write from the discarded instruction.
- With CPU_HALT_EN: 0xFFFFFFFF at imem[2] -> pc frozen at 8, later instructions never commit.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I constants, funct3 codes and ALU operation enum
package rv32i_pkg;
  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
endpackage

// File: rtl/rv32i_dmem_if.sv
// rtl/rv32i_dmem_if.sv - data memory port between core and data memory
interface rv32i_dmem_if;
  import rv32i_pkg::*;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            we;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/rv32i_dmem.sv
// rtl/rv32i_dmem.sv - word-only data memory, combinational read, write on rising edge
module rv32i_dmem
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input logic         clk,
  rv32i_dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [0:DEPTH-1] = '{default: '0};
  logic [AW-1:0]   idx;
  logic            unused_addr_bits;

  assign idx              = bus.addr[AW+1:2];
  assign bus.rdata        = mem[idx];
  assign unused_addr_bits = ^{bus.addr[XLEN-1:AW+2], bus.addr[1:0]};

  // store port; byte offset bits are ignored so every store is a full word
  always_ff @(posedge clk) begin
    if (bus.we) mem[idx] <= bus.wdata;
  end
endmodule

// File: rtl/rv32i_imem.sv
// rtl/rv32i_imem.sv - instruction ROM with combinational fetch, word index wraps on upper pc bits
module rv32i_imem
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);
  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] imem [0:DEPTH-1] = '{default: '0};
  logic            unused_pc_bits;

  assign instr          = imem[pc[AW+1:2]];
  assign unused_pc_bits = ^{pc[XLEN-1:AW+2], pc[1:0]};
endmodule

// File: rtl/rv32i_regfile.sv
// rtl/rv32i_regfile.sv - 32x32 register file, two async read ports, one write port, x0 hardwired to zero
module rv32i_regfile
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            we,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  logic [XLEN-1:0] regs [0:31] = '{default: '0};

  assign rd1 = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rd2 = (rs2 == 5'd0) ? '0 : regs[rs2];

  // write port; x0 writes are dropped so regs[0] never leaves zero
  always_ff @(posedge clk) begin
    if (we && (rd != 5'd0)) regs[rd] <= wd;
  end
endmodule

// File: rtl/rv32i_sc_core.sv
// rtl/rv32i_sc_core.sv - single-cycle RV32I core top; `define CPU_HALT_EN adds a sticky halt on 32'hFFFFFFFF
module rv32i_sc_core
  import rv32i_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input logic clk,
  input logic rst
);
  logic [XLEN-1:0] pc, pc_next, instr;
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic            alt;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic [XLEN-1:0] rs1_data, rs2_data, alu_b, alu_result, reg_wd;
  logic [4:0]      shamt;
  alu_op_e         alu_op;
  logic            branch_taken, reg_we, commit_en, stop;

  rv32i_dmem_if dbus ();

  rv32i_imem #(.DEPTH(IMEM_DEPTH)) u_imem (.pc(pc), .instr(instr));

  rv32i_regfile u_regfile (
    .clk(clk), .we(reg_we), .rs1(rs1), .rs2(rs2), .rd(rd),
    .wd(reg_wd), .rd1(rs1_data), .rd2(rs2_data)
  );

  rv32i_dmem #(.DEPTH(DMEM_DEPTH)) u_mem (.clk(clk), .bus(dbus));

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign alt    = instr[30];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  // second operand: register for R-type, store offset for stores, I-immediate otherwise
  assign alu_b = (opcode == OP_R)     ? rs2_data :
                 (opcode == OP_STORE) ? imm_s    : imm_i;
  assign shamt = alu_b[4:0];

`ifdef CPU_HALT_EN
  logic halted;
  logic halt_now;
  assign halt_now = (instr == 32'hFFFFFFFF);
  assign stop     = halted | halt_now;

  // sticky halt flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)           halted <= 1'b0;
    else if (halt_now) halted <= 1'b1;
  end
`else
  assign stop = 1'b0;
`endif

  // ALU operation select; loads/stores/others fall through to ADD for address generation
  always_comb begin
    alu_op = ALU_ADD;
    if ((opcode == OP_R) || (opcode == OP_IMM)) begin
      case (funct3)
        F3_ADD:  alu_op = ((opcode == OP_R) && alt) ? ALU_SUB : ALU_ADD;
        F3_SLL:  alu_op = ALU_SLL;
        F3_SLT:  alu_op = ALU_SLT;
        F3_SLTU: alu_op = ALU_SLTU;
        F3_XOR:  alu_op = ALU_XOR;
        F3_SR:   alu_op = alt ? ALU_SRA : ALU_SRL;
        F3_OR:   alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

  // ALU datapath; result doubles as the load/store byte address
  always_comb begin
    alu_result = rs1_data + alu_b;
    case (alu_op)
      ALU_SUB:  alu_result = rs1_data - alu_b;
      ALU_SLL:  alu_result = rs1_data << shamt;
      ALU_SLT:  alu_result = {31'd0, $signed(rs1_data) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'd0, rs1_data < alu_b};
      ALU_XOR:  alu_result = rs1_data ^ alu_b;
      ALU_SRL:  alu_result = rs1_data >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(rs1_data) >>> shamt);
      ALU_OR:   alu_result = rs1_data | alu_b;
      ALU_AND:  alu_result = rs1_data & alu_b;
      default:  alu_result = rs1_data + alu_b;
    endcase
  end

  assign commit_en    = !rst && !stop;
  assign branch_taken = (opcode == OP_BRANCH) &&
                        (((funct3 == F3_BEQ) && (rs1_data == rs2_data)) ||
                         ((funct3 == F3_BNE) && (rs1_data != rs2_data)));

  assign reg_we = commit_en &&
                  ((opcode == OP_R) || (opcode == OP_IMM) || (opcode == OP_LOAD));
  assign reg_wd = (opcode == OP_LOAD) ? dbus.rdata : alu_result;

  assign dbus.addr  = alu_result;
  assign dbus.wdata = rs2_data;
  assign dbus.we    = commit_en && (opcode == OP_STORE);

  assign pc_next = stop         ? pc :
                   branch_taken ? pc + imm_b : pc + 32'd4;

  // program counter
  always_ff @(posedge clk) begin
    if (rst) pc <= '0;
    else     pc <= pc_next;
  end
endmodule

// File: tb/tb_rv32i_sc_core.sv
// tb/tb_rv32i_sc_core.sv - self-checking bench for rv32i_sc_core with an instruction-level reference model
module tb_rv32i_sc_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_sc_core #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (.clk(clk), .rst(rst));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [256];
  logic [31:0] m_imem [256];
  logic [31:0] m_pc;
  bit          m_halted;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input bit alt, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_step(input bit r);
    logic [31:0] ins, a, b, addr, res, nxt;
    logic [2:0]  f3;
    bit          wr;
    if (r) begin m_pc = 0; m_halted = 0; return; end
    if (m_halted) return;
    ins = m_imem[m_pc[9:2]];
`ifdef CPU_HALT_EN
    if (ins == 32'hFFFFFFFF) begin m_halted = 1; return; end
`endif
    a = m_regs[ins[19:15]];
    b = m_regs[ins[24:20]];
    f3 = ins[14:12];
    wr = 0; res = 0;
    nxt = m_pc + 4;
    case (ins[6:0])
      7'h33: begin res = ref_alu(f3, ins[30], a, b); wr = 1; end
      7'h13: begin res = ref_alu(f3, (f3 == 3'd5) && ins[30], a, sext12(ins[31:20])); wr = 1; end
      7'h03: begin addr = a + sext12(ins[31:20]); res = m_mem[addr[9:2]]; wr = 1; end
      7'h23: begin addr = a + sext12({ins[31:25], ins[11:7]}); m_mem[addr[9:2]] = b; end
      7'h63: if ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b))
               nxt = m_pc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      default: ;
    endcase
    if (wr && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
    m_pc = nxt;
  endtask

  task automatic tick(input bit r);
    rst = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
  endtask

  task automatic clear_all();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin dut.u_regfile.regs[i] = 0; m_regs[i] = 0; end
    for (int i = 0; i < 256; i++) begin
      dut.u_mem.mem[i] = 0;   m_mem[i] = 0;
      dut.u_imem.imem[i] = 0; m_imem[i] = 0;
    end
  endtask

  task automatic set_reg(input int i, input logic [31:0] v);
    dut.u_regfile.regs[i] = v; m_regs[i] = v;
  endtask
  task automatic set_mem(input int i, input logic [31:0] v);
    dut.u_mem.mem[i] = v; m_mem[i] = v;
  endtask
  task automatic set_imem(input int i, input logic [31:0] v);
    dut.u_imem.imem[i] = v; m_imem[i] = v;
  endtask

  task automatic test_reset();
    clear_all();
    set_imem(0, enc_i(12'd7, 5'd0, 3'd0, 5'd1, 7'h13));
    tick(1); tick(1);
    n_checks++; if (dut.pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected 00000000", dut.pc); end
    n_checks++; if (dut.u_regfile.regs[1] !== 32'd0) begin n_fail++; $display("FAIL reset_no_wb: x1 got %h expected 00000000", dut.u_regfile.regs[1]); end
  endtask

  task automatic test_rtype_chain();
    clear_all();
    set_reg(1, 10); set_reg(2, 20); set_reg(3, 7);
    set_imem(0, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd5));
    set_imem(1, enc_r(7'h00, 5'd3, 5'd5, 3'd0, 5'd6));
    tick(1); tick(0); tick(0);
    n_checks++; if (dut.u_regfile.regs[5] !== 32'd30) begin n_fail++; $display("FAIL rchain_x5: got %0d expected 30", dut.u_regfile.regs[5]); end
    n_checks++; if (dut.u_regfile.regs[6] !== 32'd37) begin n_fail++; $display("FAIL rchain_x6: got %0d expected 37", dut.u_regfile.regs[6]); end
    tick(0);
    n_checks++; if (dut.pc !== 32'd12) begin n_fail++; $display("FAIL nop_pc: got %h expected 0000000c", dut.pc); end
    n_checks++; if (dut.u_regfile.regs[6] !== 32'd37) begin n_fail++; $display("FAIL nop_x6: got %0d expected 37", dut.u_regfile.regs[6]); end
  endtask

  task automatic test_itype();
    clear_all();
    set_reg(1, 42);
    set_imem(3, enc_i(12'd5, 5'd1, 3'd0, 5'd2, 7'h13));
    tick(1); repeat (4) tick(0);
    n_checks++; if (dut.u_regfile.regs[2] !== 32'd47) begin n_fail++; $display("FAIL addi_x2: got %0d expected 47", dut.u_regfile.regs[2]); end
    n_checks++; if (dut.u_regfile.regs[1] !== 32'd42) begin n_fail++; $display("FAIL addi_x1: got %0d expected 42", dut.u_regfile.regs[1]); end
  endtask

  task automatic test_store();
    clear_all();
    set_reg(1, 42); set_reg(3, 7);
    set_imem(6, enc_s(12'd8, 5'd3, 5'd1));
    tick(1); repeat (7) tick(0);
    n_checks++; if (dut.u_mem.mem[12] !== 32'd7) begin n_fail++; $display("FAIL sw_mem12: got %h expected 00000007", dut.u_mem.mem[12]); end
  endtask

  task automatic test_load_negimm();
    clear_all();
    set_mem(4, 32'hDEADBEEF); set_reg(1, 20);
    set_imem(0, enc_i(12'hFFC, 5'd1, 3'd2, 5'd7, 7'h03));
    set_imem(1, enc_i(12'hFFF, 5'd0, 3'd0, 5'd8, 7'h13));
    tick(1); tick(0); tick(0);
    n_checks++; if (dut.u_regfile.regs[7] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_x7: got %h expected deadbeef", dut.u_regfile.regs[7]); end
    n_checks++; if (dut.u_regfile.regs[8] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_neg_x8: got %h expected ffffffff", dut.u_regfile.regs[8]); end
  endtask

  task automatic test_branch_x0();
    clear_all();
    set_reg(1, 5); set_reg(2, 6);
    set_imem(0, enc_b(13'd8, 5'd1, 5'd1, 3'd0));
    set_imem(1, enc_i(12'd1, 5'd0, 3'd0, 5'd9, 7'h13));
    set_imem(2, enc_b(13'd8, 5'd1, 5'd1, 3'd1));
    set_imem(3, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0));
    set_imem(4, enc_i(12'd3, 5'd0, 3'd0, 5'd10, 7'h13));
    tick(1); tick(0);
    n_checks++; if (dut.pc !== 32'd8) begin n_fail++; $display("FAIL beq_pc: got %h expected 00000008", dut.pc); end
    tick(0);
    n_checks++; if (dut.pc !== 32'd12) begin n_fail++; $display("FAIL bne_pc: got %h expected 0000000c", dut.pc); end
    tick(0); tick(0);
    n_checks++; if (dut.u_regfile.regs[9] !== 32'd0) begin n_fail++; $display("FAIL beq_skip_x9: got %h expected 00000000", dut.u_regfile.regs[9]); end
    n_checks++; if (dut.u_regfile.regs[0] !== 32'd0) begin n_fail++; $display("FAIL x0_write: got %h expected 00000000", dut.u_regfile.regs[0]); end
    n_checks++; if (dut.u_regfile.regs[10] !== 32'd3) begin n_fail++; $display("FAIL br_x10: got %h expected 00000003", dut.u_regfile.regs[10]); end
    n_checks++; if (dut.pc !== 32'd20) begin n_fail++; $display("FAIL br_final_pc: got %h expected 00000014", dut.pc); end
  endtask

  task automatic test_reset_midrun();
    clear_all();
    for (int i = 0; i < 8; i++) set_imem(i, enc_i(12'(i + 1), 5'd0, 3'd0, 5'(i + 1), 7'h13));
    tick(1); repeat (4) tick(0);
    n_checks++; if (dut.pc !== 32'h10) begin n_fail++; $display("FAIL mid_pre_pc: got %h expected 00000010", dut.pc); end
    tick(1);
    n_checks++; if (dut.pc !== 32'd0) begin n_fail++; $display("FAIL mid_rst_pc: got %h expected 00000000", dut.pc); end
    n_checks++; if (dut.u_regfile.regs[5] !== 32'd0) begin n_fail++; $display("FAIL mid_discard_x5: got %h expected 00000000", dut.u_regfile.regs[5]); end
    tick(0);
    n_checks++; if (dut.pc !== 32'd4) begin n_fail++; $display("FAIL mid_restart_pc: got %h expected 00000004", dut.pc); end
    n_checks++; if (dut.u_regfile.regs[4] !== 32'd4) begin n_fail++; $display("FAIL mid_keep_x4: got %h expected 00000004", dut.u_regfile.regs[4]); end
  endtask

  task automatic test_halt();
    clear_all();
    set_imem(0, enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13));
    set_imem(1, enc_i(12'd2, 5'd0, 3'd0, 5'd2, 7'h13));
    set_imem(2, 32'hFFFFFFFF);
    set_imem(3, enc_i(12'd3, 5'd0, 3'd0, 5'd3, 7'h13));
    set_imem(4, enc_s(12'd0, 5'd1, 5'd0));
    tick(1); repeat (6) tick(0);
`ifdef CPU_HALT_EN
    n_checks++; if (dut.pc !== 32'd8) begin n_fail++; $display("FAIL halt_pc: got %h expected 00000008", dut.pc); end
    n_checks++; if (dut.u_regfile.regs[3] !== 32'd0) begin n_fail++; $display("FAIL halt_x3: got %h expected 00000000", dut.u_regfile.regs[3]); end
    n_checks++; if (dut.u_mem.mem[0] !== 32'd0) begin n_fail++; $display("FAIL halt_mem0: got %h expected 00000000", dut.u_mem.mem[0]); end
`else
    n_checks++; if (dut.pc !== 32'd24) begin n_fail++; $display("FAIL nohalt_pc: got %h expected 00000018", dut.pc); end
    n_checks++; if (dut.u_regfile.regs[3] !== 32'd3) begin n_fail++; $display("FAIL nohalt_x3: got %h expected 00000003", dut.u_regfile.regs[3]); end
    n_checks++; if (dut.u_mem.mem[0] !== 32'd1) begin n_fail++; $display("FAIL nohalt_mem0: got %h expected 00000001", dut.u_mem.mem[0]); end
`endif
    tick(1); tick(0);
    n_checks++; if (dut.pc !== 32'd4) begin n_fail++; $display("FAIL halt_clear_pc: got %h expected 00000004", dut.pc); end
  endtask

  function automatic logic [31:0] rand_instr();
    int          k, o;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] r, t;
    k = $urandom_range(0, 9);
    rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    r = $urandom; imm = r[11:0];
    if (k <= 2) return enc_r(((f3 == 3'd0 || f3 == 3'd5) && r[20]) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
    if (k <= 5) begin
      if (f3 == 3'd1) imm[11:5] = 7'h00;
      if (f3 == 3'd5) imm[11:5] = r[21] ? 7'h20 : 7'h00;
      return enc_i(imm, rs1, f3, rd, 7'h13);
    end
    if (k == 6) return enc_i(imm, rs1, 3'd2, rd, 7'h03);
    if (k == 7) return enc_s(imm, rs2, rs1);
    if (k == 8) begin
      o = int'($urandom_range(0, 8)) - 4;
      t = 32'(o * 4);
      return enc_b(t[12:0], rs1, rs2, f3);
    end
    return {r[31:7], 7'h37};
  endfunction

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      clear_all();
      for (int i = 1; i < 8; i++) set_reg(i, $urandom);
      for (int i = 0; i < 256; i++) set_mem(i, $urandom);
      for (int i = 0; i < 48; i++) set_imem(i, rand_instr());
      tick(1);
      for (int c = 0; c < 60; c++) begin
        tick(0);
        n_checks++;
        if (dut.pc !== m_pc) begin n_fail++; $display("FAIL rand_pc it %0d cyc %0d: got %h expected %h", it, c, dut.pc, m_pc); end
      end
      for (int i = 0; i < 32; i++) begin
        n_checks++;
        if (dut.u_regfile.regs[i] !== m_regs[i]) begin n_fail++; $display("FAIL rand_reg it %0d x%0d: got %h expected %h", it, i, dut.u_regfile.regs[i], m_regs[i]); end
      end
      for (int i = 0; i < 256; i++) begin
        n_checks++;
        if (dut.u_mem.mem[i] !== m_mem[i]) begin n_fail++; $display("FAIL rand_mem it %0d w%0d: got %h expected %h", it, i, dut.u_mem.mem[i], m_mem[i]); end
      end
    end
  endtask

  initial begin
    m_pc = 0; m_halted = 0;
    @(negedge clk);
    test_reset();
    test_rtype_chain();
    test_itype();
    test_store();
    test_load_negimm();
    test_branch_x0();
    test_reset_midrun();
    test_halt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
